// File: rtl/intr_priority_resolver_pkg.sv
`default_nettype none
// ============================================================================
// Package     : intr_pkg
// Description : Shared sizes, FSM state encoding and priority helpers for the
//               6-input interrupt priority resolver.
// Revision    : 1.0 - initial release
// ============================================================================
package intr_pkg;

  localparam int NUM_IRQ = 6;
  localparam int CODE_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Encoded vector of the highest set bit: bit5->1 ... bit0->6, none->0.
  function automatic logic [CODE_W-1:0] prio_code(input logic [NUM_IRQ-1:0] vec);
    logic [CODE_W-1:0] code;
    code = '0;
    // Ascending scan so the highest set bit is the last one written.
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (vec[i]) begin
        code = CODE_W'(NUM_IRQ - i);
      end
    end
    return code;
  endfunction

  // One-hot of the highest set bit; zero when the vector is empty.
  function automatic logic [NUM_IRQ-1:0] highest_bit(input logic [NUM_IRQ-1:0] vec);
    logic [NUM_IRQ-1:0] onehot;
    onehot = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (vec[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
    return onehot;
  endfunction

  // Inverse of prio_code: line one-hot for a code 1..6, zero for any other code.
  function automatic logic [NUM_IRQ-1:0] code_onehot(input logic [CODE_W-1:0] code);
    logic [NUM_IRQ-1:0] onehot;
    onehot = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (code == CODE_W'(NUM_IRQ - i)) begin
        onehot[i] = 1'b1;
      end
    end
    return onehot;
  endfunction

endpackage : intr_pkg
`default_nettype wire

// File: rtl/intr_priority_resolver_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : irq_edge_sync
// Description : Synchronises one asynchronous IRQ line into the clk domain
//               and emits a single-cycle pulse on each synchronised 0->1.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_edge_sync #(
  parameter int SYNC_LEN = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic edge_pulse
);

  logic [SYNC_LEN-1:0] r_sync;
  logic                r_prev;

  // Synchroniser chain plus one delayed copy of its output for the edge compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_LEN-2:0], async_in};
      r_prev <= r_sync[SYNC_LEN-1];
    end
  end

  // A line held high yields exactly one pulse.
  assign edge_pulse = r_sync[SYNC_LEN-1] & ~r_prev;

endmodule : irq_edge_sync
`default_nettype wire

// File: rtl/intr_priority_resolver.sv
`default_nettype none
// ============================================================================
// Module      : intr_priority_resolver
// Description : Upstream stage of the 6-input interrupt controller. Latches
//               synchronised IRQ edges into the IRR, applies the mask,
//               resolves the highest eligible request under fully nested
//               priority and runs the INTA/EOI handshake maintaining the ISR.
// Revision    : 1.0 - initial release
// ============================================================================
module intr_priority_resolver
  import intr_pkg::*;
#(
  parameter int SYNC_LEN = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic              int_ack,
  input  logic              eoi,
  output logic              int_req,
  output logic [CODE_W-1:0] irq_code,
  output logic [NUM_IRQ-1:0] isr_out
);

  // --------------------------------------------------------------------------
  // Per-line synchronisers and edge detectors
  // --------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] w_edge;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    irq_edge_sync #(
      .SYNC_LEN (SYNC_LEN)
    ) u_sync (
      .clk        (clk),
      .reset_n    (reset_n),
      .async_in   (irq_in[i]),
      .edge_pulse (w_edge[i])
    );
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_int_req;
  logic               w_int_req_nxt;
  logic [CODE_W-1:0]  r_irq_code;
  logic [CODE_W-1:0]  w_irq_code_nxt;
  logic [NUM_IRQ-1:0] r_irr;
  logic [NUM_IRQ-1:0] r_isr;
  logic [NUM_IRQ-1:0] w_irr_nxt;
  logic [NUM_IRQ-1:0] w_isr_nxt;

  // --------------------------------------------------------------------------
  // Eligibility: the top pending line must outrank the top in-service line.
  // Comparing the two one-hots numerically orders them by bit position, and
  // an empty ISR (zero) is outranked by any pending line.
  // --------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] w_pending;
  logic [NUM_IRQ-1:0] w_top_pend;
  logic [NUM_IRQ-1:0] w_top_isr;
  logic               w_eligible;

  assign w_pending  = r_irr & ~imr;
  assign w_top_pend = highest_bit(w_pending);
  assign w_top_isr  = highest_bit(r_isr);
  assign w_eligible = (|w_pending) && (w_top_pend > w_top_isr);

  // --------------------------------------------------------------------------
  // Acknowledge / end-of-interrupt effects on IRR and ISR.
  // The acked line is the one the CPU saw on irq_code, which is always a
  // valid non-zero code while in REQ.
  // --------------------------------------------------------------------------
  logic               w_ack_fire;
  logic [NUM_IRQ-1:0] w_ack_bit;
  logic [NUM_IRQ-1:0] w_eoi_clr;

  assign w_ack_fire = (r_state == REQ) && int_ack;
  assign w_ack_bit  = w_ack_fire ? code_onehot(r_irq_code) : '0;
  assign w_eoi_clr  = eoi ? w_top_isr : '0;

  // EOI acts on the old ISR first, then the acked line is set; a fresh edge
  // on the acked line overrides its IRR clear.
  always_comb begin
    w_isr_nxt = (r_isr & ~w_eoi_clr) | w_ack_bit;
    w_irr_nxt = (r_irr & ~w_ack_bit) | w_edge;
  end

  // Request/in-service registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irr <= '0;
      r_isr <= '0;
    end else begin
      r_irr <= w_irr_nxt;
      r_isr <= w_isr_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Handshake FSM. Outputs are computed as next values so that int_req and
  // irq_code leave registers.
  // --------------------------------------------------------------------------

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_int_req_nxt  = 1'b0;
    w_irq_code_nxt = '0;
    case (r_state)
      IDLE: begin
        if (w_eligible) begin
          w_state_nxt    = REQ;
          w_int_req_nxt  = 1'b1;
          w_irq_code_nxt = prio_code(w_pending);
        end
      end
      REQ: begin
        if (int_ack) begin
          // Hold the acked vector one more cycle for the decode stage.
          w_state_nxt    = ACK;
          w_irq_code_nxt = r_irq_code;
        end else if (!w_eligible) begin
          w_state_nxt = IDLE;
        end else begin
          // Re-resolve so a higher late arrival replaces the pending vector.
          w_int_req_nxt  = 1'b1;
          w_irq_code_nxt = prio_code(w_pending);
        end
      end
      ACK: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_int_req  <= 1'b0;
      r_irq_code <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_int_req  <= w_int_req_nxt;
      r_irq_code <= w_irq_code_nxt;
    end
  end

  assign int_req  = r_int_req;
  assign irq_code = r_irq_code;
  assign isr_out  = r_isr;

endmodule : intr_priority_resolver
`default_nettype wire
